// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Front-end issuer for the 4-bit ALU. Accepts one instruction (opcode plus
// two operands) over a valid/ready request channel, checks the opcode,
// drives the ALU control/operand buses, waits ALU_LATENCY cycles and then
// captures the result-mux output onto a valid/ready response channel.
//
// Optional feature: define ALU_FLAGS_EN to register a zero flag alongside
// the captured result. Without it rsp_zero is tied low (port still present).
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req_valid/req_ready              request handshake
//   req_op, req_a, req_b             opcode and operands (sampled at accept)
//   alu_control, alu_a, alu_b        registered buses to the ALU / result mux
//   alu_result                       result-mux output from the ALU
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_illegal, rsp_zero  captured result and flags
//   busy                             high whenever the sequencer is not idle
module alu_op_sequencer #(
  parameter int DATA_W      = 4,
  parameter int ALU_LATENCY = 1   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_illegal,
  output logic              rsp_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        alu_control_q, alu_control_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_illegal_q, rsp_illegal_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              zero_cap;

  // Legal opcodes: ADD 0100, SUB 0101, and every code 1000..1111.
  function automatic logic op_legal(input logic [3:0] op);
    return op[3] | (op[3:1] == 3'b010);
  endfunction

`ifdef ALU_FLAGS_EN
  assign zero_cap = (alu_result == '0);
`else
  assign zero_cap = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    alu_control_d = alu_control_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    cnt_d         = cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_zero_d    = rsp_zero_q;
    case (state_q)
      IDLE: begin
        // req_ready is high in IDLE, so req_valid alone means a handshake.
        if (req_valid) begin
          if (op_legal(req_op)) begin
            alu_control_d = req_op;
            alu_a_d       = req_a;
            alu_b_d       = req_b;
            cnt_d         = CNT_INIT;
            state_d       = WAIT;
          end else begin
            // ALU buses keep their previous values for an illegal opcode.
            rsp_data_d    = '0;
            rsp_illegal_d = 1'b1;
            rsp_zero_d    = 1'b0;
            state_d       = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d    = alu_result;
          rsp_illegal_d = 1'b0;
          rsp_zero_d    = zero_cap;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_control_q <= 4'b0000;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      cnt_q         <= 4'd0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_control_q <= alu_control_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      cnt_q         <= cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_zero_q    <= rsp_zero_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign alu_control = alu_control_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_zero    = rsp_zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Two instances (ALU_LATENCY 1 and 3) share
// the request and rsp_ready stimulus; each has its own ALU stand-in and its
// own expected-response queue checked by an independent monitor.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_op = 4'd0, req_a = 4'd0, req_b = 4'd0;
  logic       rsp_ready = 1'b1;

  logic       req_ready0, rsp_valid0, rsp_illegal0, rsp_zero0, busy0;
  logic [3:0] alu_control0, alu_a0, alu_b0, alu_res0, rsp_data0;
  logic       req_ready1, rsp_valid1, rsp_illegal1, rsp_zero1, busy1;
  logic [3:0] alu_control1, alu_a1, alu_b1, alu_res1, rsp_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

`ifdef ALU_FLAGS_EN
  localparam logic ZEXP = 1'b1;
`else
  localparam logic ZEXP = 1'b0;
`endif

  typedef struct {
    logic [3:0] data;
    logic       ill;
    logic       zero;
    int         acc;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stand-in: the real ALU plus result mux seen by each sequencer.
  function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'b0100: return a + b;
      4'b0101: return a - b;
      4'b1000: return ~a;
      4'b1001: return a | b;
      4'b1010: return a & b;
      4'b1011: return a ^ b;
      4'b1100: return a << b;
      4'b1101: return a >> b;
      4'b1110: return 4'($signed(a) >>> b);
      4'b1111: return a;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_res0 = alu_f(alu_control0, alu_a0, alu_b0);
  assign alu_res1 = alu_f(alu_control1, alu_a1, alu_b1);

  alu_op_sequencer #(.DATA_W(4), .ALU_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_control(alu_control0), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_result(alu_res0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data0), .rsp_illegal(rsp_illegal0), .rsp_zero(rsp_zero0),
    .busy(busy0)
  );

  alu_op_sequencer #(.DATA_W(4), .ALU_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_control(alu_control1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_result(alu_res1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data1), .rsp_illegal(rsp_illegal1), .rsp_zero(rsp_zero1),
    .busy(busy1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor for the latency-1 instance.
  logic pv0 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 <= 1'b0;
    end else begin
      pv0 <= rsp_valid0;
      if (rsp_valid0) begin
        if (q0.size() == 0) begin
          fail_now("u0 unexpected rsp_valid");
        end else begin
          if (!pv0) chk("u0 rsp latency", cyc - q0[0].acc, q0[0].lat);
          chk("u0 rsp_data", rsp_data0, q0[0].data);
          chk("u0 rsp_illegal", rsp_illegal0, q0[0].ill);
          chk("u0 rsp_zero", rsp_zero0, q0[0].zero);
          if (rsp_ready) void'(q0.pop_front());
        end
      end
    end
  end

  // Monitor for the latency-3 instance.
  logic pv1 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv1 <= 1'b0;
    end else begin
      pv1 <= rsp_valid1;
      if (rsp_valid1) begin
        if (q1.size() == 0) begin
          fail_now("u1 unexpected rsp_valid");
        end else begin
          if (!pv1) chk("u1 rsp latency", cyc - q1[0].acc, q1[0].lat);
          chk("u1 rsp_data", rsp_data1, q1[0].data);
          chk("u1 rsp_illegal", rsp_illegal1, q1[0].ill);
          chk("u1 rsp_zero", rsp_zero1, q1[0].zero);
          if (rsp_ready) void'(q1.pop_front());
        end
      end
    end
  end

  // Present a request, wait (bounded) for both instances to take it, and
  // optionally queue the hand-computed response.
  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic ill, input logic z, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    while (!(req_ready0 && req_ready1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      fail_now("request accept timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    last_acc = cyc;
    if (push) begin
      e.data = d; e.ill = ill; e.zero = z; e.acc = cyc;
      e.lat = ill ? 0 : 1;
      q0.push_back(e);
      e.lat = ill ? 0 : 3;
      q1.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready0 && req_ready1 && q0.size() == 0 && q1.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("idle wait timeout");
  endtask

  initial begin
    int rel;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset alu_control", alu_control0, 4'b0000);
    chk("reset rsp_valid", rsp_valid0, 1'b0);
    chk("reset busy", busy0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready", req_ready0, 1'b1);
    chk("reset rsp_data", rsp_data0, 4'd0);
    chk("reset rsp_illegal", rsp_illegal0, 1'b0);
    chk("reset rsp_zero", rsp_zero0, 1'b0);
    chk("reset alu_a", alu_a0, 4'd0);
    chk("reset alu_b", alu_b1, 4'd0);

    // ADD 3+4 = 7
    issue(4'b0100, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 1'b1);
    chk("add alu_control", alu_control0, 4'b0100);
    chk("add alu_a", alu_a0, 4'd3);
    chk("add busy", busy0, 1'b1);
    wait_idle();

    // Illegal opcode 0001: buses unchanged, immediate illegal response
    issue(4'b0001, 4'd5, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1);
    chk("illegal alu_control held", alu_control0, 4'b0100);
    chk("illegal alu_a held", alu_a0, 4'd3);
    chk("illegal alu_b held", alu_b1, 4'd4);
    wait_idle();

    // SRA 1000 >>> 1 = 1100 with response back-pressure; a CPY waits behind it
    rsp_ready = 1'b0;
    issue(4'b1110, 4'b1000, 4'b0001, 4'b1100, 1'b0, 1'b0, 1'b1);
    rel = 0;
    fork
      issue(4'b1111, 4'd9, 4'd1, 4'd9, 1'b0, 1'b0, 1'b1);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("stall req_ready", req_ready0, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        rel = cyc;
      end
    join
    // rsp handshake at edge rel+1, next request accepted at edge rel+2
    chk("accept after rsp handshake", last_acc, rel + 2);
    wait_idle();

    // XOR 1010 ^ 0110 = 1100; busy on the latency-3 instance
    issue(4'b1011, 4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0, 1'b1);
    chk("xor busy at accept", busy1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("xor busy in flight", busy1, 1'b1);
    end
    wait_idle();
    chk("xor busy after done", busy1, 1'b0);

    // XOR 0101 ^ 0101 = 0: zero flag
    issue(4'b1011, 4'b0101, 4'b0101, 4'b0000, 1'b0, ZEXP, 1'b1);
    wait_idle();

    // Reset during WAIT of an AND: response discarded
    issue(4'b1010, 4'b1100, 4'b1010, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset alu_control u0", alu_control0, 4'b0000);
    chk("midreset alu_control u1", alu_control1, 4'b0000);
    chk("midreset busy", busy1, 1'b0);
    chk("midreset rsp_valid", rsp_valid1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-reset req_ready", req_ready1, 1'b1);

    // ADD 1+1 = 2 after reset
    issue(4'b0100, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
